// File: rtl/pipe_add_pkg.sv
// Shared constants, stage-count helper and per-stage control record for pipe_add_nbit.
package pipe_add_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_SEG_W = 4;

    // Operand skew and sum deskew fields depend on WIDTH, so they live in the
    // top-level stage arrays; only the width-independent part is shared here.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

    function automatic int calc_stages(input int width, input int seg_w);
        return width / seg_w;
    endfunction

endpackage

// File: rtl/pipe_add_seg.sv
// One SEG_W-bit ripple segment of pipe_add_nbit plus its enabled stage register.
module pipe_add_seg
    import pipe_add_pkg::*;
#(
    parameter int SEG_W = DEFAULT_SEG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             prev_valid,
    input  logic             prev_carry,
    input  logic [SEG_W-1:0] seg_a,
    input  logic [SEG_W-1:0] seg_b,
    output logic             valid,
    output logic             carry,
    output logic [SEG_W-1:0] psum
);

    logic [SEG_W-1:0] sum_c;
    logic [SEG_W:0]   cy;

    always_comb begin
        sum_c = '0;
        cy    = '0;
        cy[0] = prev_carry;
        for (int i = 0; i < SEG_W; i++) begin
            sum_c[i]  = seg_a[i] ^ seg_b[i] ^ cy[i];
            cy[i+1]   = (seg_a[i] & seg_b[i]) | (cy[i] & (seg_a[i] ^ seg_b[i]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            carry <= 1'b0;
            psum  <= '0;
        end else if (en) begin
            valid <= prev_valid;
            carry <= cy[SEG_W];
            psum  <= sum_c;
        end
    end

endmodule

// File: rtl/pipe_add_nbit.sv
// Pipelined ripple-carry adder, one register stage per SEG_W segment, valid/ready handshake.
// Optional overflow output enabled by defining PIPE_ADD_OVF_EN.
module pipe_add_nbit
    import pipe_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SEG_W = DEFAULT_SEG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef PIPE_ADD_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int STAGES = calc_stages(WIDTH, SEG_W);

    if (SEG_W < 1 || WIDTH % SEG_W != 0) begin : g_bad_width
        $fatal(1, "pipe_add_nbit: WIDTH must be a positive multiple of SEG_W");
    end

    logic stall;
    logic en;

    stage_ctl_t       ctl   [STAGES];
    logic [SEG_W-1:0] psum  [STAGES];
    logic [WIDTH-1:0] a_sk  [STAGES];
    logic [WIDTH-1:0] b_sk  [STAGES];
    logic [WIDTH-1:0] s_dk  [STAGES];
    logic [WIDTH-1:0] a_src [STAGES];
    logic [WIDTH-1:0] b_src [STAGES];
    logic [WIDTH-1:0] s_src [STAGES];
    logic             v_src [STAGES];
    logic             c_src [STAGES];

    assign stall    = out_valid && !out_ready;
    assign en       = !stall;
    assign in_ready = !stall;

    // Stage k sees operands skewed by k cycles and the sum segments completed so far.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            a_src[k] = '0;
            b_src[k] = '0;
            s_src[k] = '0;
            v_src[k] = 1'b0;
            c_src[k] = 1'b0;
        end
        a_src[0] = a;
        b_src[0] = b;
        v_src[0] = in_valid && in_ready;
        c_src[0] = carry_in;
        for (int k = 1; k < STAGES; k++) begin
            a_src[k] = a_sk[k-1];
            b_src[k] = b_sk[k-1];
            v_src[k] = ctl[k-1].valid;
            c_src[k] = ctl[k-1].carry;
            s_src[k] = s_dk[k-1];
            s_src[k][(k-1)*SEG_W +: SEG_W] = psum[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : gen_stage
        pipe_add_seg #(
            .SEG_W (SEG_W)
        ) u_seg (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en),
            .prev_valid (v_src[k]),
            .prev_carry (c_src[k]),
            .seg_a      (a_src[k][k*SEG_W +: SEG_W]),
            .seg_b      (b_src[k][k*SEG_W +: SEG_W]),
            .valid      (ctl[k].valid),
            .carry      (ctl[k].carry),
            .psum       (psum[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_sk[k] <= '0;
                b_sk[k] <= '0;
                s_dk[k] <= '0;
            end
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                a_sk[k] <= a_src[k];
                b_sk[k] <= b_src[k];
                s_dk[k] <= s_src[k];
            end
        end
    end

    always_comb begin
        sum = s_dk[STAGES-1];
        sum[(STAGES-1)*SEG_W +: SEG_W] = psum[STAGES-1];
    end

    assign out_valid = ctl[STAGES-1].valid;
    assign carry_out = ctl[STAGES-1].carry;

`ifdef PIPE_ADD_OVF_EN
    // a^b^sum at the MSB recovers the carry into the MSB.
    assign overflow = a_sk[STAGES-1][WIDTH-1] ^ b_sk[STAGES-1][WIDTH-1]
                    ^ sum[WIDTH-1] ^ carry_out;
`endif

endmodule

// File: tb/tb_pipe_add_nbit.sv
// Directed self-checking bench for pipe_add_nbit at default parameters (WIDTH=16, SEG_W=4).
module tb_pipe_add_nbit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        carry_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        carry_out;
`ifdef PIPE_ADD_OVF_EN
    logic        overflow;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_add_nbit #(
        .WIDTH (16),
        .SEG_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
`ifdef PIPE_ADD_OVF_EN
        ,
        .overflow  (overflow)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] aa, input logic [15:0] bb, input logic ci);
        in_valid = v;
        a        = aa;
        b        = bb;
        carry_in = ci;
    endtask

    task automatic test_reset();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (sum !== 16'h0000) begin bad++; $display("FAIL reset_sum got=%h want=0000", sum); end
        total++; if (carry_out !== 1'b0) begin bad++; $display("FAIL reset_carry_out got=%b want=0", carry_out); end
`ifdef PIPE_ADD_OVF_EN
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
`endif
    endtask

    // 0+0+1: out_valid exactly on the 4th edge after the capture setup, for one cycle.
    task automatic test_latency();
        out_ready = 1'b1;
        drive(1'b1, 16'h0000, 16'h0000, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 1) drive(1'b0, 16'h0000, 16'h0000, 1'b0);
            total++;
            if (out_valid !== (i == 4)) begin
                bad++; $display("FAIL latency_out_valid edge=%0d got=%b want=%b", i, out_valid, (i == 4));
            end
            if (i == 4) begin
                total++; if (sum !== 16'h0001) begin bad++; $display("FAIL latency_sum got=%h want=0001", sum); end
                total++; if (carry_out !== 1'b0) begin bad++; $display("FAIL latency_carry got=%b want=0", carry_out); end
            end
        end
    endtask

    task automatic test_wrap();
        drive(1'b1, 16'hFFFF, 16'h0001, 1'b0);
        step();
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);
        step(); step(); step();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL wrap_out_valid got=%b want=1", out_valid); end
        total++; if (sum !== 16'h0000) begin bad++; $display("FAIL wrap_sum got=%h want=0000", sum); end
        total++; if (carry_out !== 1'b1) begin bad++; $display("FAIL wrap_carry got=%b want=1", carry_out); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [4];
        logic [15:0] vb [4];
        logic [15:0] es [4];
        logic        ec [4];
        va = '{16'h0003, 16'h1234, 16'h8000, 16'h00FF};
        vb = '{16'h0006, 16'h1111, 16'h8000, 16'h0001};
        es = '{16'h0009, 16'h2345, 16'h0000, 16'h0100};
        ec = '{1'b0, 1'b0, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, va[j], vb[j], 1'b0);
            step();
        end
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);
        for (int j = 0; j < 4; j++) begin
            if (j > 0) step();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got=%b want=1", j, out_valid); end
            total++; if (sum !== es[j]) begin bad++; $display("FAIL b2b_sum[%0d] got=%h want=%h", j, sum, es[j]); end
            total++; if (carry_out !== ec[j]) begin bad++; $display("FAIL b2b_carry[%0d] got=%b want=%b", j, carry_out, ec[j]); end
        end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b want=0", out_valid); end
    endtask

    task automatic test_stall();
        logic [15:0] va [4];
        logic [15:0] vb [4];
        logic        vc [4];
        logic [15:0] es [4];
        logic        ec [4];
        va = '{16'h0102, 16'hF000, 16'h5555, 16'h0F0F};
        vb = '{16'h0304, 16'h1000, 16'hAAAA, 16'h00F1};
        vc = '{1'b0, 1'b0, 1'b1, 1'b0};
        es = '{16'h0406, 16'h0000, 16'h0000, 16'h1000};
        ec = '{1'b0, 1'b1, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, va[j], vb[j], vc[j]);
            step();
        end
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);
        out_ready = 1'b0;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b want=0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_hold_ready[%0d] got=%b want=0", i, in_ready); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_hold_valid[%0d] got=%b want=1", i, out_valid); end
            total++; if (sum !== es[0]) begin bad++; $display("FAIL stall_hold_sum[%0d] got=%h want=%h", i, sum, es[0]); end
            total++; if (carry_out !== ec[0]) begin bad++; $display("FAIL stall_hold_carry[%0d] got=%b want=%b", i, carry_out, ec[0]); end
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%b want=1", in_ready); end
        for (int j = 1; j < 4; j++) begin
            step();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL drain_valid[%0d] got=%b want=1", j, out_valid); end
            total++; if (sum !== es[j]) begin bad++; $display("FAIL drain_sum[%0d] got=%h want=%h", j, sum, es[j]); end
            total++; if (carry_out !== ec[j]) begin bad++; $display("FAIL drain_carry[%0d] got=%b want=%b", j, carry_out, ec[j]); end
        end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_no_dup got=%b want=0", out_valid); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, 16'h0011 * 16'(j + 1), 16'h0100, 1'b0);
            step();
        end
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre_valid got=%b want=1", out_valid); end
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
        total++; if (sum !== 16'h0000) begin bad++; $display("FAIL midrst_sum got=%h want=0000", sum); end
        total++; if (carry_out !== 1'b0) begin bad++; $display("FAIL midrst_carry got=%b want=0", carry_out); end
        #2;
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
        for (int i = 0; i < 6; i++) begin
            step();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_stale[%0d] got=%b want=0", i, out_valid); end
        end
    endtask

    task automatic test_signed();
        logic [15:0] va [4];
        logic [15:0] vb [4];
        logic [15:0] es [4];
        logic        ec [4];
        logic        eo [4];
        va = '{16'h7FFF, 16'h0001, 16'h8000, 16'hFFFF};
        vb = '{16'h0001, 16'h0001, 16'h8000, 16'h0001};
        es = '{16'h8000, 16'h0002, 16'h0000, 16'h0000};
        ec = '{1'b0, 1'b0, 1'b1, 1'b1};
        eo = '{1'b1, 1'b0, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, va[j], vb[j], 1'b0);
            step();
        end
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);
        for (int j = 0; j < 4; j++) begin
            if (j > 0) step();
            total++; if (sum !== es[j]) begin bad++; $display("FAIL signed_sum[%0d] got=%h want=%h", j, sum, es[j]); end
            total++; if (carry_out !== ec[j]) begin bad++; $display("FAIL signed_carry[%0d] got=%b want=%b", j, carry_out, ec[j]); end
`ifdef PIPE_ADD_OVF_EN
            total++; if (overflow !== eo[j]) begin bad++; $display("FAIL signed_overflow[%0d] got=%b want=%b", j, overflow, eo[j]); end
`else
            if (eo[j] === 1'bx) $display("unexpected X in overflow table");
`endif
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        #3;
        rst_n = 1'b1;
        step();
        test_reset();
        test_latency();
        test_wrap();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_signed();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
